// File: rtl/layer_neuron_mac_if.sv
`default_nettype none
// ============================================================================
// Module   : layer_neuron_mac_if
// Brief    : Operand, finalize and result handshake bundle for one neuron MAC.
//            The master side is the term counter plus the downstream layer.
//            The slave side is layer_neuron_mac.
// Revision : 1.0 - initial release
// ============================================================================
interface layer_neuron_mac_if #(
    parameter int DATA_W = 8
);
    logic                     ack;
    logic signed [DATA_W-1:0] x;
    logic signed [DATA_W-1:0] w;
    logic signed [DATA_W-1:0] bias;
    logic                     ack__mac;
    logic                     out_ack;
    logic                     ack__out;
    logic signed [DATA_W-1:0] y;
    logic                     busy;

    modport master (
        output ack, x, w, bias, ack__mac, out_ack,
        input  ack__out, y, busy
    );

    modport slave (
        input  ack, x, w, bias, ack__mac, out_ack,
        output ack__out, y, busy
    );
endinterface
`default_nettype wire

// File: rtl/layer_neuron_mac.sv
`default_nettype none
// ============================================================================
// Module   : layer_neuron_mac
// Brief    : Signed multiply-accumulate for one fully-connected neuron.
//            Each ack accumulates x*w. A rising edge on ack__mac finalizes:
//            the bias is added, the sum is rescaled, and ReLU with
//            saturation is applied. The result is then held until out_ack.
//            All state changes on the falling clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module layer_neuron_mac #(
    parameter int DATA_W = 8,
    parameter int FRAC_W = 4,
    parameter int ACC_W  = 24   // must be >= 2*DATA_W + 8
) (
    input  logic               clk,
    input  logic               rst,   // asynchronous, active low
    layer_neuron_mac_if.slave  bus
);

    localparam int PROD_W = 2 * DATA_W;

    // Largest positive output code, 2^(DATA_W-1)-1, at accumulator width.
    localparam logic signed [ACC_W-1:0] c_y_max =
        {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t                    r_state;
    logic signed [ACC_W-1:0]   r_acc;
    logic                      r_mac_d;
    logic signed [DATA_W-1:0]  r_y;
    logic                      r_ack_out;
    logic                      r_busy;

    logic signed [PROD_W-1:0]  w_prod;
    logic signed [ACC_W-1:0]   w_prod_ext;
    logic signed [ACC_W-1:0]   w_term;
    logic signed [ACC_W-1:0]   w_bias_ext;
    logic signed [ACC_W-1:0]   w_sum;
    logic signed [ACC_W-1:0]   w_shift;
    logic signed [DATA_W-1:0]  w_y_sat;
    logic                      w_fin;

    // The product carries 2*FRAC_W fraction bits, and so does the accumulator.
    assign w_prod     = bus.x * bus.w;
    assign w_prod_ext = {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};

    // The bias is aligned to 2*FRAC_W fraction bits before it is added.
    assign w_bias_ext = {{(ACC_W-DATA_W-FRAC_W){bus.bias[DATA_W-1]}},
                         bus.bias, {FRAC_W{1'b0}}};

    // A term that arrives on the finalizing edge still counts toward the sum.
    assign w_term  = bus.ack ? w_prod_ext : '0;
    assign w_sum   = r_acc + w_term + w_bias_ext;
    assign w_shift = w_sum >>> FRAC_W;

    // The ack__mac flag is sticky, so only its 0->1 transition finalizes.
    assign w_fin   = bus.ack__mac & ~r_mac_d;

    // ReLU at the bottom and saturation at the top of the output range.
    always_comb begin
        w_y_sat = '0;
        if (w_shift[ACC_W-1]) begin
            w_y_sat = '0;
        end else if (w_shift > c_y_max) begin
            w_y_sat = c_y_max[DATA_W-1:0];
        end else begin
            w_y_sat = w_shift[DATA_W-1:0];
        end
    end

    // Control FSM, accumulator and registered outputs, all on the falling edge.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_acc     <= '0;
            r_mac_d   <= 1'b0;
            r_y       <= '0;
            r_ack_out <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_mac_d <= bus.ack__mac;
            case (r_state)
                S_IDLE: begin
                    if (w_fin) begin
                        r_y       <= w_y_sat;
                        r_ack_out <= 1'b1;
                        r_busy    <= 1'b1;
                        r_state   <= S_HOLD;
                    end else if (bus.ack) begin
                        r_acc     <= w_prod_ext;
                        r_busy    <= 1'b1;
                        r_state   <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (w_fin) begin
                        r_y       <= w_y_sat;
                        r_ack_out <= 1'b1;
                        r_busy    <= 1'b1;
                        r_state   <= S_HOLD;
                    end else if (bus.ack) begin
                        r_acc     <= r_acc + w_prod_ext;
                    end
                end
                S_HOLD: begin
                    // New terms and finalize requests are ignored until consumed.
                    if (bus.out_ack) begin
                        r_ack_out <= 1'b0;
                        r_acc     <= '0;
                        r_busy    <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    r_ack_out <= 1'b0;
                    r_busy    <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.y        = r_y;
    assign bus.ack__out = r_ack_out;
    assign bus.busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_layer_neuron_mac.sv
`default_nettype none
// ============================================================================
// Module   : tb_layer_neuron_mac
// Brief    : Self-checking bench for layer_neuron_mac (DATA_W=8, FRAC_W=4).
//            Expected activations are queued when a sum is finalized and
//            compared when ack__out rises.
// Revision : 1.0 - initial release
// ============================================================================
module tb_layer_neuron_mac;

    logic clk;
    logic rst;

    layer_neuron_mac_if #(.DATA_W(8)) bus ();

    layer_neuron_mac #(
        .DATA_W (8),
        .FRAC_W (4),
        .ACC_W  (24)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int m_sum   = 0;
    int sb[$];
    bit prev_out = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference activation: floor((sum + bias*16) / 16), clamped to [0,127].
    function automatic int model_y(input int acc, input int b);
        int s;
        int r;
        s = acc + b * 16;
        r = s >>> 4;
        if (r < 0)   r = 0;
        if (r > 127) r = 127;
        return r;
    endfunction

    // Result monitor: each new ack__out pops one expectation.
    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                prev_out = 1'b0;
            end else begin
                if (bus.ack__out && !prev_out) begin
                    if (sb.size() == 0) begin
                        check_eq("unexpected_out", 32'd1, 32'd0);
                    end else begin
                        check_eq("y", 32'(bus.y), 32'(sb.pop_front()));
                    end
                end
                prev_out = bus.ack__out;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic term(input int xv, input int wv);
        logic [31:0] xb;
        logic [31:0] wb;
        xb = xv;
        wb = wv;
        @(posedge clk);
        bus.ack = 1'b1;
        bus.x   = xb[7:0];
        bus.w   = wb[7:0];
        m_sum  += xv * wv;
    endtask

    task automatic idle();
        @(posedge clk);
        bus.ack = 1'b0;
    endtask

    // Raise ack__mac (optionally with a same-edge term) and check 1-clock latency.
    task automatic finalize(input int b, input bit with_ack, input int xv, input int wv);
        logic [31:0] bb;
        logic [31:0] xb;
        logic [31:0] wb;
        bb = b;
        xb = xv;
        wb = wv;
        @(posedge clk);
        bus.ack = with_ack;
        if (with_ack) begin
            bus.x  = xb[7:0];
            bus.w  = wb[7:0];
            m_sum += xv * wv;
        end
        bus.bias     = bb[7:0];
        bus.ack__mac = 1'b1;
        sb.push_back(model_y(m_sum, b));
        m_sum = 0;
        @(posedge clk);
        bus.ack = 1'b0;
        check_eq("latency_ack_out", 32'(bus.ack__out), 32'd1);
    endtask

    task automatic consume(input bit keep_mac);
        @(posedge clk);
        bus.ack     = 1'b0;
        bus.out_ack = 1'b1;
        if (!keep_mac) bus.ack__mac = 1'b0;
        @(posedge clk);
        bus.out_ack = 1'b0;
        check_eq("ack_out_clear", 32'(bus.ack__out), 32'd0);
        check_eq("busy_idle", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        rst          = 1'b0;
        bus.ack      = 1'b0;
        bus.x        = '0;
        bus.w        = '0;
        bus.bias     = '0;
        bus.ack__mac = 1'b0;
        bus.out_ack  = 1'b0;
        repeat (2) @(posedge clk);
        check_eq("rst_ack_out", 32'(bus.ack__out), 32'd0);
        check_eq("rst_y", 32'(bus.y), 32'd0);
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        @(posedge clk);
        rst = 1'b1;

        // Basic sum: 1.0*1.0 + 1.0*1.0 - 1.0 = 1.0
        term(16, 16);
        idle();
        check_eq("busy_accum", 32'(bus.busy), 32'd1);
        term(16, 16);
        finalize(-16, 1'b0, 0, 0);
        consume(1'b0);

        // ReLU clamp of a negative sum.
        term(16, -16);
        term(16, -16);
        finalize(0, 1'b0, 0, 0);
        consume(1'b0);

        // Truncation of a sub-LSB product.
        term(1, 1);
        finalize(0, 1'b0, 0, 0);
        consume(1'b0);

        // Saturation at +127.
        term(127, 127);
        term(127, 127);
        finalize(127, 1'b0, 0, 0);
        consume(1'b0);

        // Last term on the same edge that first sees ack__mac high.
        term(16, 16);
        finalize(0, 1'b1, 16, 32);
        consume(1'b0);

        // HOLD ignores terms and a still-high ack__mac.
        term(16, 32);
        finalize(0, 1'b0, 0, 0);
        @(posedge clk);
        bus.ack = 1'b1;
        bus.x   = 8'sd127;
        bus.w   = 8'sd127;
        @(posedge clk);
        bus.ack = 1'b0;
        check_eq("hold_y", 32'(bus.y), 32'd32);
        check_eq("hold_ack_out", 32'(bus.ack__out), 32'd1);
        consume(1'b1);
        repeat (3) idle();
        check_eq("no_retrigger", 32'(bus.ack__out), 32'd0);
        @(posedge clk);
        bus.ack__mac = 1'b0;
        finalize(16, 1'b0, 0, 0);
        consume(1'b0);

        // Reset in ACCUM discards the partial sum.
        term(16, 16);
        term(16, 16);
        @(posedge clk);
        bus.ack = 1'b0;
        #1 rst = 1'b0;
        #1;
        check_eq("rst_accum_ack_out", 32'(bus.ack__out), 32'd0);
        check_eq("rst_accum_y", 32'(bus.y), 32'd0);
        check_eq("rst_accum_busy", 32'(bus.busy), 32'd0);
        m_sum = 0;
        #1 rst = 1'b1;
        term(16, 16);
        finalize(0, 1'b0, 0, 0);

        // Reset in HOLD; ack__mac still high at release acts as a new rising edge.
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check_eq("rst_hold_ack_out", 32'(bus.ack__out), 32'd0);
        check_eq("rst_hold_y", 32'(bus.y), 32'd0);
        check_eq("rst_hold_busy", 32'(bus.busy), 32'd0);
        bus.bias = 8'sd32;
        sb.push_back(model_y(0, 32));
        #1 rst = 1'b1;
        @(posedge clk);
        check_eq("release_ack_out", 32'(bus.ack__out), 32'd1);
        consume(1'b0);

        repeat (2) idle();
        check_eq("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/layer_neuron_mac.md
# layer_neuron_mac

Multiply-accumulate stage for one neuron of a fully-connected layer. It sits directly downstream of the layer's term counter. Each `ack` strobe accumulates one signed weight×input product, and the counter's sticky `ack__mac` flag triggers finalization. Finalization adds the bias, rescales, applies ReLU with saturation, and hands the activation to the next layer over a valid/ack handshake.

## Interface
Parameters:
- `DATA_W`, 8: width of `x`, `w`, `bias` and `y`; signed fixed-point.
- `FRAC_W`, 4: fractional bits of `x`, `w`, `bias` and `y`.
- `ACC_W`, 24: accumulator width. Must be at least 2·DATA_W + 8.

Ports (clock and reset first):
- `clk`  in  1  clock; all state updates on the falling edge.
- `rst`  in  1  asynchronous, active-low reset.
- `ack`  in  1  operand-pair strobe; same signal that drives the term counter.
- `x`  in  DATA_W  signed input activation, valid when `ack`=1.
- `w`  in  DATA_W  signed weight, valid when `ack`=1.
- `bias`  in  DATA_W  signed bias, sampled at finalization.
- `ack__mac`  in  1  last-term flag from the counter; sticky level.
- `out_ack`  in  1  downstream has consumed `y`.
- `ack__out`  out  1  `y` valid.
- `y`  out  DATA_W  signed activation result.
- `busy`  out  1  high in ACCUM and HOLD.

## Operation
- States: IDLE, ACCUM, HOLD.
- `mac_d` is a register holding `ack__mac` from the previous edge. `fin` = `ack__mac` & ~`mac_d`, a rising-edge detect.
- Products: `x*w` is a signed 2·DATA_W value with 2·FRAC_W fractional bits. It is sign-extended to ACC_W. The accumulator wraps modulo 2^ACC_W, with no saturation.
- IDLE, `ack`=1: `acc` ← `p`, go to ACCUM.
- IDLE, `fin`=1: finalize with the current `acc`. It is 0 unless the accumulator was left nonzero.
- ACCUM, `ack`=1 and `fin`=0: `acc` ← `acc` + `p`.
- ACCUM, `fin`=1: finalize. If `ack`=1 on the same edge, that product is included before the bias is added.
- Finalize:
  - `s` = `acc` + `p`(if `ack`) + (sign-extended `bias` << FRAC_W).
  - `r` = `s` >>> FRAC_W, an arithmetic shift that truncates toward −∞.
  - `y` ← 0 if `r` < 0; 2^(DATA_W−1)−1 if `r` exceeds that value; `r` otherwise.
  - `ack__out` ← 1, go to HOLD.
- HOLD:
  - `ack` is ignored and does not accumulate.
  - `fin` is ignored.
  - `y` is held stable.
  - `out_ack`=1: `ack__out` ← 0, `acc` ← 0, go to IDLE.
- `ack__mac` remaining high after HOLD does not trigger a second result. Only a new 0→1 transition does.
- Reset (`rst`=0, asynchronous, any time, including mid-accumulation or in HOLD):
  - state ← IDLE.
  - `acc`, `mac_d`, `y`, `ack__out`, `busy` ← 0.
  - Any partial sum is discarded.

## Timing
- Accumulate latency: the product is in `acc` after the falling edge that samples `ack`=1.
- The counter raises `ack__mac` on the edge that accepts the last term. This block samples it high on the next falling edge.
- On that same next edge, `ack__out` goes to 1 and `y` becomes valid. Latency from the last term's `ack` to valid output is 1 clock.
- `ack__out` stays high until `out_ack` is sampled at 1. It clears on that edge. The earliest new accumulation is the following edge.
- `out_ack` sampled in IDLE or ACCUM has no effect.
- `busy` is registered and follows the state: 1 in ACCUM and HOLD, 0 in IDLE.
- Reset release: the first falling edge after `rst` goes high operates normally.
- An `ack__mac` already high at reset release is seen as a rising edge at that first edge.

## Test plan
All scenarios use DATA_W=8, FRAC_W=4.
1. Basic sum: two acks with (`x`,`w`) = (16,16),(16,16), `bias`=−16, then `ack__mac` rises. Required: `y`=16, `ack__out`=1 exactly 1 clock after `ack__mac` rises; `out_ack` clears it and `busy`=0.
2. ReLU clamp: (16,−16),(16,−16), `bias`=0. Required: `y`=0. Truncation: a single (1,1), `bias`=0. Required: `y`=0.
3. Saturation: (127,127),(127,127), `bias`=127. Required: `y`=127, with no wrap to a negative value.
4. Same-edge last term: `ack`=1 on the same edge `ack__mac` is first sampled high, with (16,32) after a prior (16,16), `bias`=0. Required: `y`=48.
5. HOLD behaviour: in HOLD, pulse `ack` with (127,127) and keep `ack__mac` high. Required: `y` unchanged, no second `ack__out` after `out_ack`. Then drop `ack__mac`, raise it again with no terms and `bias`=16. Required: `y`=16.
6. Reset mid-operation: assert `rst`=0 between two edges in ACCUM, and again in HOLD. Required: `ack__out`, `y`, `busy` are 0 immediately, and the next sum excludes the earlier terms.
